// File: rtl/ascon_pl_stage_if.sv
// ascon_pl_stage_if: valid/ready stream carrying one 320-bit Ascon state plus a last tag
interface ascon_pl_stage_if;
  logic valid;
  logic ready;
  logic [319:0] state;
  logic last;
  modport master (output valid, state, last, input ready);
  modport slave (input valid, state, last, output ready);
endinterface

// File: rtl/ascon_pl_stage.sv
// ascon_pl_stage: registered Ascon pL linear-diffusion stage with valid/ready handshake
// Define ASCON_PL_SKID_EN for a skid register and a registered s.ready.
module ascon_pl_stage (
  input logic clk,
  input logic rst,
  ascon_pl_stage_if.slave s,
  ascon_pl_stage_if.master m
);
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  logic [63:0] x0, x1, x2, x3, x4;
  logic [319:0] d;
  logic valid_q, last_q, acc, dn;
  logic [319:0] state_q;
  assign {x0, x1, x2, x3, x4} = s.state;
  assign d = {x0 ^ ror(x0, 19) ^ ror(x0, 28),
              x1 ^ ror(x1, 61) ^ ror(x1, 39),
              x2 ^ ror(x2, 1)  ^ ror(x2, 6),
              x3 ^ ror(x3, 10) ^ ror(x3, 17),
              x4 ^ ror(x4, 7)  ^ ror(x4, 41)};
  assign acc = s.valid && s.ready;
  assign dn = valid_q && m.ready;
  assign m.valid = valid_q;
  assign m.state = state_q;
  assign m.last = last_q;
`ifdef ASCON_PL_SKID_EN
  logic sk_valid, sk_last;
  logic [319:0] sk_state;
  // Ready depends only on skid occupancy, never on m.ready.
  assign s.ready = !rst && !sk_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      state_q <= '0;
      last_q <= 1'b0;
      sk_valid <= 1'b0;
      sk_state <= '0;
      sk_last <= 1'b0;
    end else if (!valid_q || dn) begin
      if (sk_valid) begin
        valid_q <= 1'b1;
        state_q <= sk_state;
        last_q <= sk_last;
        sk_valid <= 1'b0;
      end else begin
        valid_q <= acc;
        if (acc) begin
          state_q <= d;
          last_q <= s.last;
        end
      end
    end else if (acc) begin
      sk_valid <= 1'b1;
      sk_state <= d;
      sk_last <= s.last;
    end
  end
`else
  assign s.ready = !rst && (!valid_q || m.ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      state_q <= '0;
      last_q <= 1'b0;
    end else if (acc) begin
      valid_q <= 1'b1;
      state_q <= d;
      last_q <= s.last;
    end else if (dn) begin
      valid_q <= 1'b0;
    end
  end
`endif
endmodule
